register_file_24bit: RTL and testbench
======================================

Name: register_file_24bit

Overview:
- Register file for the 24-bit single-cycle CPU; sits directly upstream of the ALU.
- Two combinational read ports drive the ALU A and B operands.
- One clocked write port takes write-back data, normally the ALU Result or memory data.
- A 3-bit status-flag register captures the ALU Zero/Overflow/CarryOut outputs for later conditional branches.

Parameters:
- DATA_W, 24, register and port data width; must equal the ALU width.
- ADDR_W, 3, register index width; the file holds 2**ADDR_W = 8 registers.
- ZERO_REG, 0, index of the register hardwired to zero.

Ports:
- Clock  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- RS  input  ADDR_W  read address, port 1.
- RT  input  ADDR_W  read address, port 2.
- RD  input  ADDR_W  write address.
- RegWrite  input  1  write enable for the data array.
- WriteData  input  DATA_W  write-back data.
- ReadData1  output  DATA_W  contents of register RS; feeds ALU A.
- ReadData2  output  DATA_W  contents of register RT; feeds the B mux.
- FlagWrite  input  1  load enable for the flag register.
- ZeroIn  input  1  ALU Zero.
- OverflowIn  input  1  ALU Overflow.
- CarryIn  input  1  ALU CarryOut.
- Flags  output  3  registered flags: {Carry, Overflow, Zero} = bits [2:0].
- DbgAddr  input  ADDR_W  debug/testbench read address.
- DbgData  output  DATA_W  contents of register DbgAddr.

Behaviour:
- Interface: one clock, Clock. Reset is synchronous and active-high, port Reset.
- Reset:
  - When Reset=1 at a rising edge, all 8 registers clear to 0 and Flags clear to 3'b000.
  - Reset takes priority over RegWrite and FlagWrite in the same cycle.
  - A reset mid-program discards any write presented in that cycle.
- Reads:
  - ReadData1, ReadData2 and DbgData are purely combinational from the stored array, with zero latency.
  - Outputs after reset are 0 for every address.
- Write:
  - At a rising edge with Reset=0 and RegWrite=1, reg[RD] <= WriteData.
  - The new value is visible on the read ports from the following cycle.
- No write-through bypass: a same-cycle read of RD returns the old value. This is mandatory, because ReadData feeds the ALU, whose Result feeds WriteData; a bypass would create a combinational loop.
- Register ZERO_REG:
  - Writes to it are ignored.
  - Reads of it always return 0, regardless of stored state.
- Both read ports may address the same register; each returns the identical value.
- RS/RT equal to RD with RegWrite=1: the read returns the pre-edge value and the post-edge value appears next cycle.
- Flags:
  - At a rising edge with Reset=0 and FlagWrite=1, Flags <= {CarryIn, OverflowIn, ZeroIn}. Otherwise Flags hold their value.
  - FlagWrite and RegWrite are independent; both may be asserted in the same cycle.
- No X propagation: every address value is legal, so no out-of-range case exists.

Decomposition:
- Shared package cpu24_pkg holds DATA_W=24, ADDR_W=3, NUM_REGS=8, ZERO_REG=0, and flag bit indices FLAG_Z=0, FLAG_V=1, FLAG_C=2. The ALU and control unit reuse the same package.
- One natural sub-module, reg_24bit: a DATA_W-wide register with synchronous active-high reset and load enable.
  - Instantiated 7 times for registers 1..7.
  - Register 0 is a constant, not an instance.
  - The flag register is a 3-bit instance of the same sub-module, parameterised by width.
- Read muxes and write decode live in the top module.

Test Plan:
- Reset → all registers and flags zero:
  - Write 24'hABCDEF to reg 3, then assert Reset for 1 cycle.
  - Required: ReadData1 (RS=3) = 0, Flags = 3'b000.
- Write then read next cycle, no bypass:
  - RegWrite=1, RD=5, WriteData=24'h123456, RS=5 in the same cycle.
  - Required: ReadData1 = old value (0) before the edge, 24'h123456 after the edge.
- Zero register protection:
  - RegWrite=1, RD=0, WriteData=24'hFFFFFF.
  - Required: ReadData1 (RS=0) = 0 and DbgData (DbgAddr=0) = 0 on all following cycles.
- Dual read, same and different addresses:
  - reg2 = 24'h000007, reg7 = 24'h800000.
  - RS=2, RT=7 → ReadData1 = 24'h000007, ReadData2 = 24'h800000.
  - RS=RT=7 → both outputs = 24'h800000.
- Flag capture and hold:
  - FlagWrite=1 with ZeroIn=1, OverflowIn=0, CarryIn=1 → Flags = 3'b101.
  - Next cycle FlagWrite=0 with inputs 0,1,0 → Flags stay 3'b101.
- Reset priority:
  - Reset=1, RegWrite=1, RD=4, WriteData=24'h00FF00, FlagWrite=1, all flag inputs 1, in one cycle.
  - Required after the edge: reg4 = 0, Flags = 3'b000.

Source files
------------

// File: rtl/cpu24_pkg.sv
// ---------------------------------------------------------------------------
// cpu24_pkg
// Shared constants and types for the 24-bit single-cycle CPU. The register
// file, ALU and control unit all import this package, so the datapath width
// and the flag bit layout are defined in one place.
//
// Contents:
//   DATA_W    datapath / register width (24)
//   ADDR_W    register index width (3)
//   NUM_REGS  number of architectural registers (2**ADDR_W = 8)
//   ZERO_REG  index of the register hardwired to zero
//   FLAG_*    bit positions of Zero/Overflow/Carry inside the flag register
// ---------------------------------------------------------------------------
package cpu24_pkg;

   localparam int DATA_W   = 24;
   localparam int ADDR_W   = 3;
   localparam int NUM_REGS = 2 ** ADDR_W;
   localparam int ZERO_REG = 0;

   // Flag register layout: {Carry, Overflow, Zero} = bits [2:0].
   localparam int FLAG_Z = 0;
   localparam int FLAG_V = 1;
   localparam int FLAG_C = 2;
   localparam int FLAG_W = 3;

   typedef logic [DATA_W-1:0] word_t;
   typedef logic [ADDR_W-1:0] addr_t;

endpackage : cpu24_pkg

// File: rtl/reg_24bit.sv
// ---------------------------------------------------------------------------
// reg_24bit
// Generic WIDTH-bit storage register with synchronous active-high reset and
// a load enable. Used for the general-purpose registers of the register file
// and, at WIDTH = 3, for the ALU status-flag register.
//
// Ports:
//   i_clock  in   1      clock, rising edge
//   i_reset  in   1      synchronous reset, active high (clears o_q)
//   i_load   in   1      load enable; o_q takes i_d at the next edge
//   i_d      in   WIDTH  data to load
//   o_q      out  WIDTH  stored value
// ---------------------------------------------------------------------------
module reg_24bit
   import cpu24_pkg::*;
#(
   parameter int WIDTH = DATA_W
) (
   input  logic             i_clock,
   input  logic             i_reset,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_q;

   // NOTE: reset is tested first so it overrides a load presented in the
   // same cycle; sequential state is always assigned with <=.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_q <= '0;
      end else if (i_load) begin
         r_q <= i_d;
      end
   end

   assign o_q = r_q;

endmodule : reg_24bit

// File: rtl/register_file_24bit.sv
// ---------------------------------------------------------------------------
// register_file_24bit
// Eight-entry, 24-bit register file feeding the ALU operands, plus the 3-bit
// status-flag register that captures the ALU Zero/Overflow/CarryOut results
// for later conditional branches.
//
// Ports:
//   Clock       in   1       clock, all state updates on rising edge
//   Reset       in   1       synchronous reset, active high; clears all
//                            registers and flags, overrides any write
//   RS, RT      in   ADDR_W  read addresses for ports 1 and 2
//   RD          in   ADDR_W  write address
//   RegWrite    in   1       write enable for the register array
//   WriteData   in   DATA_W  write-back data
//   ReadData1   out  DATA_W  reg[RS], combinational (ALU A)
//   ReadData2   out  DATA_W  reg[RT], combinational (B mux)
//   FlagWrite   in   1       load enable for the flag register
//   ZeroIn      in   1       ALU Zero
//   OverflowIn  in   1       ALU Overflow
//   CarryIn     in   1       ALU CarryOut
//   Flags       out  3       {Carry, Overflow, Zero}
//   DbgAddr     in   ADDR_W  debug read address
//   DbgData     out  DATA_W  reg[DbgAddr], combinational
// ---------------------------------------------------------------------------
module register_file_24bit
   import cpu24_pkg::*;
#(
   parameter int DATA_W   = cpu24_pkg::DATA_W,
   parameter int ADDR_W   = cpu24_pkg::ADDR_W,
   parameter int ZERO_REG = cpu24_pkg::ZERO_REG
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic [ADDR_W-1:0] RS,
   input  logic [ADDR_W-1:0] RT,
   input  logic [ADDR_W-1:0] RD,
   input  logic              RegWrite,
   input  logic [DATA_W-1:0] WriteData,
   output logic [DATA_W-1:0] ReadData1,
   output logic [DATA_W-1:0] ReadData2,
   input  logic              FlagWrite,
   input  logic              ZeroIn,
   input  logic              OverflowIn,
   input  logic              CarryIn,
   output logic [FLAG_W-1:0] Flags,
   input  logic [ADDR_W-1:0] DbgAddr,
   output logic [DATA_W-1:0] DbgData
);

   localparam int NUM_REGS_L = 2 ** ADDR_W;

   // Current contents of every register as seen by the read muxes.
   logic [DATA_W-1:0] w_regs [NUM_REGS_L];

   // Flag register next-state vector, assembled by bit index so the layout
   // stays tied to the package definition.
   logic [FLAG_W-1:0] w_flags_d;

   // ------------------------------------------------------------------
   // Register array: the zero register is a constant, every other entry
   // is a reg_24bit whose load is the decoded write enable for its index.
   // ------------------------------------------------------------------
   for (genvar g = 0; g < NUM_REGS_L; g++) begin : g_regs
      if (g == ZERO_REG) begin : g_zero
         assign w_regs[g] = '0;
      end else begin : g_store
         logic w_load;

         assign w_load = RegWrite && (RD == ADDR_W'(g));

         reg_24bit #(
            .WIDTH (DATA_W)
         ) u_reg (
            .i_clock (Clock),
            .i_reset (Reset),
            .i_load  (w_load),
            .i_d     (WriteData),
            .o_q     (w_regs[g])
         );
      end
   end

   // ------------------------------------------------------------------
   // Read ports
   // ------------------------------------------------------------------
   // NOTE: reads come straight from the stored array with no write-through
   // bypass; ReadData feeds the ALU whose Result returns on WriteData, so a
   // bypass would close a combinational loop.
   assign ReadData1 = w_regs[RS];
   assign ReadData2 = w_regs[RT];
   assign DbgData   = w_regs[DbgAddr];

   // ------------------------------------------------------------------
   // Status flags
   // ------------------------------------------------------------------
   always_comb begin
      w_flags_d         = '0;
      w_flags_d[FLAG_Z] = ZeroIn;
      w_flags_d[FLAG_V] = OverflowIn;
      w_flags_d[FLAG_C] = CarryIn;
   end

   reg_24bit #(
      .WIDTH (FLAG_W)
   ) u_flags (
      .i_clock (Clock),
      .i_reset (Reset),
      .i_load  (FlagWrite),
      .i_d     (w_flags_d),
      .o_q     (Flags)
   );

endmodule : register_file_24bit

// File: tb/tb_register_file_24bit.sv
// ---------------------------------------------------------------------------
// tb_register_file_24bit
// Directed scenarios followed by randomized traffic, all compared against a
// simple array model of eight registers and a flag word.
// ---------------------------------------------------------------------------
module tb_register_file_24bit;

   logic        Clock = 1'b0;
   logic        Reset;
   logic [2:0]  RS, RT, RD, DbgAddr;
   logic        RegWrite, FlagWrite;
   logic [23:0] WriteData;
   logic        ZeroIn, OverflowIn, CarryIn;
   logic [23:0] ReadData1, ReadData2, DbgData;
   logic [2:0]  Flags;

   int checks   = 0;
   int failures = 0;

   // Reference model: architectural register contents and flag word.
   logic [23:0] model_regs [8];
   logic [2:0]  model_flags;

   register_file_24bit dut (
      .Clock      (Clock),
      .Reset      (Reset),
      .RS         (RS),
      .RT         (RT),
      .RD         (RD),
      .RegWrite   (RegWrite),
      .WriteData  (WriteData),
      .ReadData1  (ReadData1),
      .ReadData2  (ReadData2),
      .FlagWrite  (FlagWrite),
      .ZeroIn     (ZeroIn),
      .OverflowIn (OverflowIn),
      .CarryIn    (CarryIn),
      .Flags      (Flags),
      .DbgAddr    (DbgAddr),
      .DbgData    (DbgData)
   );

   always #5 Clock = ~Clock;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   // Architectural value of a register: register 0 always reads zero.
   function automatic logic [23:0] arch_reg(input logic [2:0] a);
      return (a == 3'd0) ? 24'h0 : model_regs[a];
   endfunction

   task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one clock: the model absorbs whatever the inputs present at the
   // edge, then outputs are sampled 1 time unit after the edge.
   task automatic tick();
      if (Reset) begin
         foreach (model_regs[i]) model_regs[i] = 24'h0;
         model_flags = 3'b000;
      end else begin
         if (RegWrite && RD != 3'd0) model_regs[RD] = WriteData;
         if (FlagWrite) model_flags = {CarryIn, OverflowIn, ZeroIn};
      end
      @(posedge Clock);
      #1;
   endtask

   task automatic check_all_ports(input string tag);
      #1;
      check({tag, ".rd1"},   ReadData1, arch_reg(RS));
      check({tag, ".rd2"},   ReadData2, arch_reg(RT));
      check({tag, ".dbg"},   DbgData,   arch_reg(DbgAddr));
      check({tag, ".flags"}, {21'h0, Flags}, {21'h0, model_flags});
   endtask

   initial begin
      foreach (model_regs[i]) model_regs[i] = 24'hx;
      model_flags = 3'bxxx;
      Reset = 1'b1; RS = '0; RT = '0; RD = '0; DbgAddr = '0;
      RegWrite = 1'b0; FlagWrite = 1'b0; WriteData = '0;
      ZeroIn = 1'b0; OverflowIn = 1'b0; CarryIn = 1'b0;
      @(negedge Clock);
      tick();
      Reset = 1'b0;

      // Reset state: every address reads zero, flags clear.
      for (int a = 0; a < 8; a++) begin
         DbgAddr = 3'(a);
         #1;
         check($sformatf("reset_dbg%0d", a), DbgData, 24'h0);
      end
      check("reset_flags", {21'h0, Flags}, 24'h0);

      // Write reg3 then reset: contents vanish.
      RD = 3'd3; WriteData = 24'hABCDEF; RegWrite = 1'b1;
      tick();
      RegWrite = 1'b0; RS = 3'd3;
      #1;
      check("wr3_before_reset", ReadData1, 24'hABCDEF);
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      #1;
      check("reset_clears_r3", ReadData1, 24'h0);
      check("reset_clears_flags", {21'h0, Flags}, 24'h0);

      // Write then read, no bypass.
      RD = 3'd5; WriteData = 24'h123456; RegWrite = 1'b1; RS = 3'd5;
      #1;
      check("no_bypass_pre_edge", ReadData1, 24'h0);
      tick();
      RegWrite = 1'b0;
      #1;
      check("write_visible_next", ReadData1, 24'h123456);

      // Zero register protection.
      RD = 3'd0; WriteData = 24'hFFFFFF; RegWrite = 1'b1;
      tick();
      RegWrite = 1'b0; RS = 3'd0; DbgAddr = 3'd0;
      for (int c = 0; c < 3; c++) begin
         #1;
         check($sformatf("zero_rd1_c%0d", c), ReadData1, 24'h0);
         check($sformatf("zero_dbg_c%0d", c), DbgData,   24'h0);
         tick();
      end

      // Dual read, different and same addresses.
      RD = 3'd2; WriteData = 24'h000007; RegWrite = 1'b1;
      tick();
      RD = 3'd7; WriteData = 24'h800000;
      tick();
      RegWrite = 1'b0; RS = 3'd2; RT = 3'd7;
      #1;
      check("dual_rd1_r2", ReadData1, 24'h000007);
      check("dual_rd2_r7", ReadData2, 24'h800000);
      RS = 3'd7;
      #1;
      check("same_rd1_r7", ReadData1, 24'h800000);
      check("same_rd2_r7", ReadData2, 24'h800000);

      // Flag capture and hold.
      FlagWrite = 1'b1; ZeroIn = 1'b1; OverflowIn = 1'b0; CarryIn = 1'b1;
      tick();
      check("flags_capture", {21'h0, Flags}, {21'h0, 3'b101});
      FlagWrite = 1'b0; ZeroIn = 1'b0; OverflowIn = 1'b1; CarryIn = 1'b0;
      tick();
      check("flags_hold", {21'h0, Flags}, {21'h0, 3'b101});

      // Reset priority over simultaneous register and flag writes.
      RD = 3'd4; WriteData = 24'h111111; RegWrite = 1'b1;
      tick();
      DbgAddr = 3'd4;
      #1;
      check("r4_preload", DbgData, 24'h111111);
      Reset = 1'b1; RegWrite = 1'b1; RD = 3'd4; WriteData = 24'h00FF00;
      FlagWrite = 1'b1; ZeroIn = 1'b1; OverflowIn = 1'b1; CarryIn = 1'b1;
      tick();
      Reset = 1'b0; RegWrite = 1'b0; FlagWrite = 1'b0;
      #1;
      check("rst_prio_r4", DbgData, 24'h0);
      check("rst_prio_flags", {21'h0, Flags}, 24'h0);
      RS = 3'd7;
      #1;
      check("rst_prio_r7", ReadData1, 24'h0);

      // Randomized traffic against the model, including occasional resets
      // and reads of the register being written in the same cycle.
      for (int n = 0; n < 400; n++) begin
         Reset      = ($urandom_range(0, 31) == 0);
         RegWrite   = $urandom_range(0, 1) == 1;
         FlagWrite  = $urandom_range(0, 2) == 0;
         RD         = 3'($urandom_range(0, 7));
         RS         = ($urandom_range(0, 3) == 0) ? RD : 3'($urandom_range(0, 7));
         RT         = 3'($urandom_range(0, 7));
         DbgAddr    = 3'($urandom_range(0, 7));
         WriteData  = 24'($urandom);
         ZeroIn     = $urandom_range(0, 1) == 1;
         OverflowIn = $urandom_range(0, 1) == 1;
         CarryIn    = $urandom_range(0, 1) == 1;
         check_all_ports($sformatf("rand%0d", n));
         tick();
      end
      Reset = 1'b0; RegWrite = 1'b0; FlagWrite = 1'b0;
      for (int a = 0; a < 8; a++) begin
         DbgAddr = 3'(a);
         #1;
         check($sformatf("final_r%0d", a), DbgData, arch_reg(3'(a)));
      end
      check("final_flags", {21'h0, Flags}, {21'h0, model_flags});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_register_file_24bit
